// File: rtl/triangle_fetch.sv
// triangle_fetch: read side of the scene memories.
// Walks triangle indices 0..N-1, issues one shared read address to the V1/V2/V3/colour RAMs
// (1-cycle synchronous read), and streams assembled triangle records to the rasterizer over a
// valid/ready handshake. A 2-entry output FIFO absorbs downstream stalls.
//
// Ports:
//   clock, reset          single rising-edge clock, asynchronous active-high reset
//   start, num_tris       begin a pass of num_tris triangles (sampled only when idle)
//   busy, done            pass in progress / one-cycle completion pulse
//   read_addr             shared RAM read address
//   v1_q, v2_q, v3_q,     RAM read data, valid the cycle after read_addr
//   color_q
//   out_valid, out_ready  record handshake
//   out_v1/v2/v3,         head record fields
//   out_color, out_index
module triangle_fetch #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned VERT_W  = 54,
  parameter int unsigned COLOR_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W:0]    num_tris,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  read_addr,
  input  logic [VERT_W-1:0]  v1_q,
  input  logic [VERT_W-1:0]  v2_q,
  input  logic [VERT_W-1:0]  v3_q,
  input  logic [COLOR_W-1:0] color_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VERT_W-1:0]  out_v1,
  output logic [VERT_W-1:0]  out_v2,
  output logic [VERT_W-1:0]  out_v3,
  output logic [COLOR_W-1:0] out_color,
  output logic [ADDR_W-1:0]  out_index
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] MaxTris = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CntW-1:0] One     = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   total_q, total_d;
  logic [CntW-1:0]   issued_q, issued_d;
  logic [CntW-1:0]   clamped;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W-1:0] inflight_idx_q;
  logic              inflight_q;
  logic              zero_done_q, zero_done_d;

  logic [VERT_W-1:0]  fifo_v1_q    [2];
  logic [VERT_W-1:0]  fifo_v2_q    [2];
  logic [VERT_W-1:0]  fifo_v3_q    [2];
  logic [COLOR_W-1:0] fifo_color_q [2];
  logic [ADDR_W-1:0]  fifo_idx_q   [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q;

  logic       pop;
  logic       issue;
  logic       drained;
  logic [2:0] occ;

  always_comb begin
    pop     = (count_q != 2'd0) && out_ready;
    // Occupancy after this cycle's pop; the in-flight read will land in the FIFO, so it counts.
    occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue   = (state_q == StFetch) && (occ < 3'd2);
    drained = (state_q == StDrain) && (count_q == 2'd0) && !inflight_q;
    clamped = (num_tris > MaxTris) ? MaxTris : num_tris;
  end

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    issued_d    = issued_q;
    zero_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (clamped == '0) begin
            zero_done_d = 1'b1;
          end else begin
            total_d  = clamped;
            issued_d = '0;
            state_d  = StFetch;
          end
        end
      end
      StFetch: begin
        if (issue) begin
          issued_d = issued_q + One;
          if (issued_d == total_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (drained) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle) && !drained;
    done      = zero_done_q || drained;
    read_addr = issue ? issued_q[ADDR_W-1:0] : last_addr_q;
    out_valid = (count_q != 2'd0);
    out_v1    = fifo_v1_q[rd_ptr_q];
    out_v2    = fifo_v2_q[rd_ptr_q];
    out_v3    = fifo_v3_q[rd_ptr_q];
    out_color = fifo_color_q[rd_ptr_q];
    out_index = fifo_idx_q[rd_ptr_q];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      total_q        <= '0;
      issued_q       <= '0;
      last_addr_q    <= '0;
      inflight_idx_q <= '0;
      inflight_q     <= 1'b0;
      zero_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      issued_q    <= issued_d;
      zero_done_q <= zero_done_d;
      inflight_q  <= issue;
      if (issue) begin
        last_addr_q    <= issued_q[ADDR_W-1:0];
        inflight_idx_q <= issued_q[ADDR_W-1:0];
      end
    end
  end

  // Writes only ever target the non-head slot while a record is held, so the head stays stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_v1_q[i]    <= '0;
        fifo_v2_q[i]    <= '0;
        fifo_v3_q[i]    <= '0;
        fifo_color_q[i] <= '0;
        fifo_idx_q[i]   <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_v1_q[wr_ptr_q]    <= v1_q;
        fifo_v2_q[wr_ptr_q]    <= v2_q;
        fifo_v3_q[wr_ptr_q]    <= v3_q;
        fifo_color_q[wr_ptr_q] <= color_q;
        fifo_idx_q[wr_ptr_q]   <= inflight_idx_q;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_triangle_fetch.sv
// Self-checking bench for triangle_fetch: RAM model on the read port, scoreboard of expected
// records per pass, one task per scenario.
module tb_triangle_fetch;

  localparam int AW = 12;
  localparam int VW = 54;
  localparam int CW = 16;
  localparam int RW = AW + 3 * VW + CW;

  logic          clock;
  logic          reset;
  logic          start;
  logic [AW:0]   num_tris;
  logic          busy;
  logic          done;
  logic [AW-1:0] read_addr;
  logic [VW-1:0] v1_q, v2_q, v3_q;
  logic [CW-1:0] color_q;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_v1, out_v2, out_v3;
  logic [CW-1:0] out_color;
  logic [AW-1:0] out_index;
  logic [RW-1:0] rec_act;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  triangle_fetch #(
    .ADDR_W (AW),
    .VERT_W (VW),
    .COLOR_W(CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .num_tris (num_tris),
    .busy     (busy),
    .done     (done),
    .read_addr(read_addr),
    .v1_q     (v1_q),
    .v2_q     (v2_q),
    .v3_q     (v3_q),
    .color_q  (color_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_v1   (out_v1),
    .out_v2   (out_v2),
    .out_v3   (out_v3),
    .out_color(out_color),
    .out_index(out_index)
  );

  assign rec_act = {out_index, out_v1, out_v2, out_v3, out_color};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scene RAMs: synchronous read, data valid the cycle after the address.
  always @(posedge clock) begin
    v1_q    <= VW'(read_addr) + VW'(1);
    v2_q    <= VW'(read_addr) + VW'(2);
    v3_q    <= VW'(read_addr) + VW'(3);
    color_q <= CW'(read_addr) * CW'(3);
  end

  function automatic logic [RW-1:0] rec_exp(input int idx);
    logic [AW-1:0] a;
    logic [VW-1:0] e1, e2, e3;
    logic [CW-1:0] c;
    a  = AW'(idx);
    e1 = VW'(idx + 1);
    e2 = VW'(idx + 2);
    e3 = VW'(idx + 3);
    c  = CW'(idx * 3);
    return {a, e1, e2, e3, c};
  endfunction

  // Leaves the bench at the negedge just after the edge that sampled start.
  task automatic pulse_start(input int n);
    @(negedge clock);
    start    = 1'b1;
    num_tris = (AW+1)'(n);
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, out_valid} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {busy, done, out_valid});
    else n_pass++;
    n_checks++;
    if (read_addr !== '0) $display("FAIL reset_addr: got %0h want 0", read_addr);
    else n_pass++;
    n_checks++;
    if (rec_act !== '0) $display("FAIL reset_data: got %0h want 0", rec_act);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({busy, done, out_valid} !== 3'b000) $display("FAIL idle_ctrl: got %b want 000", {busy, done, out_valid});
    else n_pass++;
  endtask

  task automatic test_zero();
    int n_done, done_c, bad_busy, bad_valid, bad_addr;
    n_done = 0; done_c = -1; bad_busy = 0; bad_valid = 0; bad_addr = 0;
    out_ready = 1'b1;
    pulse_start(0);
    for (int c = 0; c < 8; c++) begin
      if (busy !== 1'b0) bad_busy++;
      if (out_valid !== 1'b0) bad_valid++;
      if (read_addr !== '0) bad_addr++;
      if (done === 1'b1) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      @(negedge clock);
    end
    n_checks++;
    if (bad_busy != 0) $display("FAIL zero_busy: got %0d busy cycles want 0", bad_busy);
    else n_pass++;
    n_checks++;
    if (bad_valid != 0) $display("FAIL zero_valid: got %0d valid cycles want 0", bad_valid);
    else n_pass++;
    n_checks++;
    if (bad_addr != 0) $display("FAIL zero_addr: got %0d nonzero cycles want 0", bad_addr);
    else n_pass++;
    n_checks++;
    if (n_done != 1) $display("FAIL zero_done_count: got %0d want 1", n_done);
    else n_pass++;
    n_checks++;
    if (done_c != 0) $display("FAIL zero_done_cycle: got %0d want 0", done_c);
    else n_pass++;
  endtask

  task automatic test_basic();
    int first_c, done_c, n_done, k, bad_seq;
    first_c = -1; done_c = -1; n_done = 0; k = 0; bad_seq = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    out_ready = 1'b1;
    pulse_start(4);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      if (out_valid === 1'b1) begin
        if (first_c < 0) first_c = c;
        if (c != first_c + k) bad_seq++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL basic_extra: got index %0d want none", out_index);
        else if (rec_act !== rec_exp(exp_q[0]))
          $display("FAIL basic_rec: got %0h want %0h", rec_act, rec_exp(exp_q[0]));
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        k++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
      @(negedge clock);
    end
    n_checks++;
    if (first_c != 2) $display("FAIL basic_latency: got %0d want 2", first_c);
    else n_pass++;
    n_checks++;
    if (bad_seq != 0) $display("FAIL basic_gap: got %0d gaps want 0", bad_seq);
    else n_pass++;
    n_checks++;
    if (k != 4 || exp_q.size() != 0) $display("FAIL basic_count: got %0d want 4", k);
    else n_pass++;
    n_checks++;
    if (n_done != 1) $display("FAIL basic_done_count: got %0d want 1", n_done);
    else n_pass++;
    n_checks++;
    if (done_c != 6) $display("FAIL basic_done_cycle: got %0d want 6", done_c);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_stall();
    int n_done, done_c, k;
    n_done = 0; done_c = -1; k = 0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(i);
    out_ready = 1'b1;
    pulse_start(5);
    for (int c = 0; c < 80; c++) begin
      out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      // Head is compared every valid cycle, so any change while stalled shows up here.
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL stall_extra: got index %0d want none", out_index);
        else if (rec_act !== rec_exp(exp_q[0]))
          $display("FAIL stall_head: got %0h want %0h", rec_act, rec_exp(exp_q[0]));
        else n_pass++;
        if (out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          k++;
        end
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
      @(negedge clock);
    end
    out_ready = 1'b1;
    n_checks++;
    if (k != 5 || exp_q.size() != 0) $display("FAIL stall_count: got %0d want 5", k);
    else n_pass++;
    n_checks++;
    if (n_done != 1) $display("FAIL stall_done_count: got %0d want 1", n_done);
    else n_pass++;
  endtask

  task automatic test_full(input int n, input int nexp);
    int n_done, done_c, k, last_idx;
    n_done = 0; done_c = -1; k = 0; last_idx = -1;
    exp_q.delete();
    for (int i = 0; i < nexp; i++) exp_q.push_back(i);
    out_ready = 1'b1;
    pulse_start(n);
    for (int c = 0; c < nexp + 40; c++) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL full_extra: got index %0d want none", out_index);
        end else if (rec_act !== rec_exp(exp_q[0])) begin
          n_checks++;
          $display("FAIL full_rec: got %0h want %0h", rec_act, rec_exp(exp_q[0]));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        last_idx = int'(out_index);
        k++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
      @(negedge clock);
    end
    n_checks++;
    if (k != nexp || exp_q.size() != 0) $display("FAIL full_count: got %0d want %0d", k, nexp);
    else n_pass++;
    n_checks++;
    if (last_idx != 4095) $display("FAIL full_last_index: got %0d want 4095", last_idx);
    else n_pass++;
    n_checks++;
    if (n_done != 1) $display("FAIL full_done_count: got %0d want 1", n_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n_done, done_c, k;
    n_done = 0; done_c = -1; k = 0;
    out_ready = 1'b0;
    pulse_start(8);
    repeat (6) @(negedge clock);
    n_checks++;
    if ({out_valid, out_index} !== {1'b1, 12'd0}) $display("FAIL mid_before: got %b/%0d want 1/0", out_valid, out_index);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, out_valid, read_addr, rec_act} !== '0)
      $display("FAIL mid_async_reset: got %0h want 0", {busy, done, out_valid, read_addr, rec_act});
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(i);
    out_ready = 1'b1;
    pulse_start(3);
    for (int c = 0; c < 40; c++) begin
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL mid_extra: got index %0d want none", out_index);
        else if (rec_act !== rec_exp(exp_q[0]))
          $display("FAIL mid_rec: got %0h want %0h", rec_act, rec_exp(exp_q[0]));
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        k++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 3) break;
      @(negedge clock);
    end
    n_checks++;
    if (k != 3) $display("FAIL mid_count: got %0d want 3", k);
    else n_pass++;
    n_checks++;
    if (n_done != 1) $display("FAIL mid_done_count: got %0d want 1", n_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n_done, done_c, k, late_valid;
    n_done = 0; done_c = -1; k = 0; late_valid = 0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(i);
    out_ready = 1'b1;
    pulse_start(6);
    for (int c = 0; c < 40; c++) begin
      start = 1'b0;
      if (c == 3) begin
        start    = 1'b1;
        num_tris = 13'd2;
      end
      if (out_valid === 1'b1) begin
        if (done_c >= 0) late_valid++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra: got index %0d want none", out_index);
        else if (rec_act !== rec_exp(exp_q[0]))
          $display("FAIL b2b_rec: got %0h want %0h", rec_act, rec_exp(exp_q[0]));
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        k++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_c < 0) begin
          done_c = c;
          start  = 1'b1;  // lands while the pass is still finishing
        end
      end
      if (done_c >= 0 && c >= done_c + 5) break;
      @(negedge clock);
    end
    start = 1'b0;
    n_checks++;
    if (k != 6 || exp_q.size() != 0) $display("FAIL b2b_count: got %0d want 6", k);
    else n_pass++;
    n_checks++;
    if (n_done != 1) $display("FAIL b2b_done_count: got %0d want 1", n_done);
    else n_pass++;
    n_checks++;
    if (late_valid != 0 || busy !== 1'b0) $display("FAIL b2b_restart: got %0d late records busy=%b want 0/0", late_valid, busy);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    num_tris  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    test_reset();
    test_zero();
    test_basic();
    test_stall();
    test_full(4096, 4096);
    test_full(5000, 4096);
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
